// File: rtl/json_uart_parser_if.sv
// json_uart_parser_if
// Byte stream handshake between the UART receiver and the JSON parser.
//   uart_data  : received byte (source -> parser)
//   uart_valid : uart_data holds a byte (source -> parser)
//   uart_ready : parser can take a byte this cycle (parser -> source)
// A byte is consumed on a rising edge where uart_valid && uart_ready.
interface json_uart_parser_if;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       uart_ready;

  modport master (output uart_data, output uart_valid, input uart_ready);
  modport slave  (input uart_data, input uart_valid, output uart_ready);
endinterface

// File: rtl/json_uart_parser.sv
// json_uart_parser
// Parses motor frames {"T":<uint>,"L":<num>,"R":<num>}<LF> from a UART byte
// stream and commits the decoded fields atomically when the LF arrives.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   uart         : byte stream in (slave side of json_uart_parser_if)
//   t_value      : last committed T field
//   left_speed   : last committed L field, signed milli-units
//   right_speed  : last committed R field, signed milli-units
//   motor_cmd    : one-hot command decoded from the last committed L/R pair
//   frame_valid  : one-cycle pulse when a frame is committed
//   frame_error  : one-cycle pulse when a frame is aborted
module json_uart_parser #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  json_uart_parser_if.slave   uart,
  output logic [7:0]          t_value,
  output logic signed [15:0]  left_speed,
  output logic signed [15:0]  right_speed,
  output logic [4:0]          motor_cmd,
  output logic                frame_valid,
  output logic                frame_error
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_POINT  = 8'h2E;
  localparam logic [7:0] CH_LF     = 8'h0A;

  localparam logic [1:0] FLD_T = 2'd0;
  localparam logic [1:0] FLD_L = 2'd1;
  localparam logic [1:0] FLD_R = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_EXP_LIT = 3'd1, ST_T_NUM = 3'd2, ST_SIGN_OR_INT = 3'd3,
    ST_POINT = 3'd4, ST_FRAC = 3'd5, ST_SEP = 3'd6, ST_EOL = 3'd7
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               ready_r;
  logic [1:0]         field_r, lit_idx_r, cnt_r;
  logic               neg_r;
  logic [13:0]        mag_r;
  logic [7:0]         t_acc_r;
  logic [15:0]        sh_l_r, sh_r_r;
  logic [TMR_W-1:0]   timer_r;

  logic               acc_s, timeout_s, is_digit_s, sep_ok_s, bad_s;
  logic [3:0]         digit_s;
  logic [11:0]        t_calc_s;
  logic [13:0]        frac_add_s;
  logic [7:0]         lit_exp_s;
  logic [15:0]        sep_val_s;
  logic [4:0]         cmd_nxt_s;
  logic               start_s, lit_adv_s, t_dig_s, neg_set_s, int_dig_s, frac_dig_s, sep_s, commit_s, err_s;

  function automatic logic [4:0] motor_decode(input logic [15:0] l, input logic [15:0] r);
    logic [4:0] cmd;
    if (l == 16'd0 && r == 16'd0) begin
      cmd = 5'b00001;
    end else if (l == 16'd100 && r == 16'd100) begin
      cmd = 5'b00010;
    end else if (l == 16'd0 && r == 16'd50) begin
      cmd = 5'b00100;
    end else if (l == 16'd50 && r == 16'd0) begin
      cmd = 5'b01000;
    end else if (l == 16'hFFCE && r == 16'd50) begin
      cmd = 5'b10000;
    end else begin
      cmd = 5'b00000;
    end
    return cmd;
  endfunction

  assign uart.uart_ready = ready_r;
  assign acc_s      = uart.uart_valid && ready_r;
  assign timeout_s  = (state_r != ST_IDLE) && !acc_s && (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));
  assign is_digit_s = (uart.uart_data >= 8'h30) && (uart.uart_data <= 8'h39);
  assign digit_s    = uart.uart_data[3:0];
  assign t_calc_s   = {4'd0, t_acc_r} * 12'd10 + {8'd0, digit_s};
  // The R field is closed by '}', the others by ','.
  assign sep_ok_s   = (field_r == FLD_R) ? (uart.uart_data == CH_RBRACE) : (uart.uart_data == CH_COMMA);
  assign sep_val_s  = neg_r ? (16'd0 - {2'b00, mag_r}) : {2'b00, mag_r};

  // Literal byte expected at the current index and weight of the next fraction digit
  always_comb begin
    lit_exp_s  = CH_QUOTE;
    frac_add_s = 14'd0;
    case (lit_idx_r)
      2'd0:    lit_exp_s = CH_QUOTE;
      2'd1:    lit_exp_s = (field_r == FLD_T) ? 8'h54 : ((field_r == FLD_L) ? 8'h4C : 8'h52);
      2'd2:    lit_exp_s = CH_QUOTE;
      default: lit_exp_s = CH_COLON;
    endcase
    // Weighting by position zero-pads short fractions (".05" -> 50).
    case (cnt_r)
      2'd0:    frac_add_s = {10'd0, digit_s} * 14'd100;
      2'd1:    frac_add_s = {10'd0, digit_s} * 14'd10;
      2'd2:    frac_add_s = {10'd0, digit_s};
      default: frac_add_s = 14'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath-action decode for the accepted byte
  always_comb begin
    state_nxt_s = state_r;
    start_s = 1'b0; lit_adv_s = 1'b0; t_dig_s = 1'b0; neg_set_s = 1'b0;
    int_dig_s = 1'b0; frac_dig_s = 1'b0; sep_s = 1'b0; commit_s = 1'b0;
    err_s = 1'b0; bad_s = 1'b0;
    if (timeout_s) begin
      err_s = 1'b1;
      state_nxt_s = ST_IDLE;
    end else if (acc_s) begin
      case (state_r)
        ST_IDLE: begin
          if (uart.uart_data == CH_LBRACE) begin
            start_s = 1'b1;
            state_nxt_s = ST_EXP_LIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EXP_LIT: begin
          if (uart.uart_data == lit_exp_s) begin
            lit_adv_s = 1'b1; // 2-bit index wraps to 0 after the colon
            if (lit_idx_r == 2'd3) begin
              state_nxt_s = (field_r == FLD_T) ? ST_T_NUM : ST_SIGN_OR_INT;
            end else begin
              state_nxt_s = ST_EXP_LIT;
            end
          end else begin
            bad_s = 1'b1;
          end
        end
        ST_T_NUM: begin
          if (is_digit_s && cnt_r < 2'd3 && t_calc_s <= 12'd255) begin
            t_dig_s = 1'b1;
            state_nxt_s = (cnt_r == 2'd2) ? ST_SEP : ST_T_NUM;
          end else if (sep_ok_s && cnt_r != 2'd0) begin
            sep_s = 1'b1;
            state_nxt_s = ST_EXP_LIT;
          end else begin
            bad_s = 1'b1;
          end
        end
        ST_SIGN_OR_INT: begin
          if (uart.uart_data == CH_MINUS && !neg_r) begin
            neg_set_s = 1'b1;
          end else if (is_digit_s) begin
            int_dig_s = 1'b1;
            state_nxt_s = ST_POINT;
          end else begin
            bad_s = 1'b1;
          end
        end
        ST_POINT: begin
          if (uart.uart_data == CH_POINT) begin
            state_nxt_s = ST_FRAC;
          end else begin
            bad_s = 1'b1;
          end
        end
        ST_FRAC: begin
          // Third digit moves to SEP, so a fourth digit is rejected there.
          if (is_digit_s && cnt_r < 2'd3) begin
            frac_dig_s = 1'b1;
            state_nxt_s = (cnt_r == 2'd2) ? ST_SEP : ST_FRAC;
          end else if (sep_ok_s && cnt_r != 2'd0) begin
            sep_s = 1'b1;
            state_nxt_s = (field_r == FLD_R) ? ST_EOL : ST_EXP_LIT;
          end else begin
            bad_s = 1'b1;
          end
        end
        ST_SEP: begin
          if (sep_ok_s) begin
            sep_s = 1'b1;
            state_nxt_s = (field_r == FLD_R) ? ST_EOL : ST_EXP_LIT;
          end else begin
            bad_s = 1'b1;
          end
        end
        ST_EOL: begin
          if (uart.uart_data == CH_LF) begin
            commit_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            bad_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
      // A '{' that breaks a frame also opens the next one.
      if (bad_s) begin
        err_s = 1'b1;
        if (uart.uart_data == CH_LBRACE) begin
          start_s = 1'b1;
          state_nxt_s = ST_EXP_LIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end else begin
        err_s = 1'b0;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: command implied by the shadow speed pair
  always_comb begin
    cmd_nxt_s = motor_decode(sh_l_r, sh_r_r);
  end

  // Field accumulators and shadow registers for the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_r <= FLD_T; lit_idx_r <= 2'd0; cnt_r <= 2'd0; neg_r <= 1'b0;
      mag_r <= 14'd0; t_acc_r <= 8'd0; sh_l_r <= 16'd0; sh_r_r <= 16'd0;
    end else if (start_s) begin
      field_r <= FLD_T; lit_idx_r <= 2'd0; cnt_r <= 2'd0; neg_r <= 1'b0;
      mag_r <= 14'd0; t_acc_r <= 8'd0;
    end else if (lit_adv_s) begin
      lit_idx_r <= lit_idx_r + 2'd1;
    end else if (t_dig_s) begin
      t_acc_r <= t_calc_s[7:0];
      cnt_r   <= cnt_r + 2'd1;
    end else if (neg_set_s) begin
      neg_r <= 1'b1;
    end else if (int_dig_s) begin
      mag_r <= {10'd0, digit_s} * 14'd1000;
      cnt_r <= 2'd0;
    end else if (frac_dig_s) begin
      mag_r <= mag_r + frac_add_s;
      cnt_r <= cnt_r + 2'd1;
    end else if (sep_s) begin
      case (field_r)
        FLD_L:   sh_l_r <= sep_val_s;
        FLD_R:   sh_r_r <= sep_val_s;
        default: sh_l_r <= sh_l_r; // T is already held in t_acc_r
      endcase
      field_r <= field_r + 2'd1;
      lit_idx_r <= 2'd0; cnt_r <= 2'd0; neg_r <= 1'b0; mag_r <= 14'd0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Inter-byte timeout counter, active only inside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (state_r == ST_IDLE || acc_s || timeout_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + 1'b1;
    end
  end

  // Registered outputs: ready, pulses and committed frame fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0; frame_valid <= 1'b0; frame_error <= 1'b0;
      t_value <= 8'd0; left_speed <= 16'sd0; right_speed <= 16'sd0; motor_cmd <= 5'b00001;
    end else begin
      ready_r     <= 1'b1;
      frame_valid <= commit_s;
      frame_error <= err_s;
      if (commit_s) begin
        t_value     <= t_acc_r;
        left_speed  <= sh_l_r;
        right_speed <= sh_r_r;
        motor_cmd   <= cmd_nxt_s;
      end
    end
  end
endmodule

// File: tb/tb_json_uart_parser.sv
// tb_json_uart_parser
// Directed frames are driven into json_uart_parser; each expected pulse is
// queued when its frame is sent and a negedge monitor pops and compares.
module tb_json_uart_parser;
  logic               clk;
  logic               rst_n;
  logic [7:0]         t_value;
  logic signed [15:0] left_speed, right_speed;
  logic [4:0]         motor_cmd;
  logic               frame_valid, frame_error;

  json_uart_parser_if u_if ();

  json_uart_parser #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .uart(u_if.slave),
    .t_value(t_value), .left_speed(left_speed), .right_speed(right_speed),
    .motor_cmd(motor_cmd), .frame_valid(frame_valid), .frame_error(frame_error)
  );

  typedef struct {
    bit                 is_err;
    logic [7:0]         t;
    logic signed [15:0] l;
    logic signed [15:0] r;
    logic [4:0]         cmd;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold;
  int   n_vec = 0;
  int   n_err = 0;
  int   err_pulses = 0;
  int   base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ok(input logic [7:0] t, input logic signed [15:0] l,
                         input logic signed [15:0] r, input logic [4:0] cmd);
    exp_t e;
    e.is_err = 1'b0; e.t = t; e.l = l; e.r = r; e.cmd = cmd;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.t = 8'd0; e.l = 16'sd0; e.r = 16'sd0; e.cmd = 5'b0;
    exp_q.push_back(e);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    u_if.uart_data  = b;
    u_if.uart_valid = 1'b1;
    while (!u_if.uart_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_wait", 64'(u_if.uart_ready), 64'(1'b1));
    @(posedge clk); #1;
    if (gap > 0) begin
      u_if.uart_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    u_if.uart_valid = 1'b0;
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue
  initial begin
    exp_t e;
    hold.is_err = 1'b0; hold.t = 8'd0; hold.l = 16'sd0; hold.r = 16'sd0; hold.cmd = 5'b00001;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold.t = 8'd0; hold.l = 16'sd0; hold.r = 16'sd0; hold.cmd = 5'b00001;
      end else if (frame_valid || frame_error) begin
        if (frame_error) err_pulses++;
        if (frame_valid && frame_error) check("pulse_exclusive", 64'(frame_error), 64'(1'b0));
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'({frame_valid, frame_error}), 64'(2'b00));
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 64'({frame_valid, frame_error}), e.is_err ? 64'(2'b01) : 64'(2'b10));
          if (!e.is_err) begin
            check("frame_data", 64'({t_value, left_speed, right_speed, motor_cmd}),
                  64'({e.t, e.l, e.r, e.cmd}));
            hold = e;
          end else begin
            check("hold_after_error", 64'({t_value, left_speed, right_speed, motor_cmd}),
                  64'({hold.t, hold.l, hold.r, hold.cmd}));
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    u_if.uart_data = 8'h00; u_if.uart_valid = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({t_value, left_speed, right_speed, motor_cmd, frame_valid, frame_error}),
          64'({8'd0, 16'd0, 16'd0, 5'b00001, 1'b0, 1'b0}));
    check("reset_ready", 64'(u_if.uart_ready), 64'(1'b0));
    rst_n = 1'b1;
    #1;
    check("ready_before_clk", 64'(u_if.uart_ready), 64'(1'b0));
    @(posedge clk); #1;
    check("ready_after_clk", 64'(u_if.uart_ready), 64'(1'b1));

    push_ok(8'd1, 16'sd100, 16'sd100, 5'b00010);
    send_str("{\"T\":1,\"L\":0.100,\"R\":0.100}\n", 0);

    push_ok(8'd1, -16'sd50, 16'sd50, 5'b10000);
    send_str("{\"T\":1,\"L\":-0.05,\"R\":0.050}\n", 3);

    push_err();
    send_str("{\"T\":1,\"L\":0.1x", 0);
    repeat (3) @(posedge clk);
    #1;
    push_ok(8'd0, 16'sd0, 16'sd0, 5'b00001);
    send_str("{\"T\":0,\"L\":0.000,\"R\":0.000}\n", 0);

    push_err();
    push_ok(8'd2, 16'sd50, 16'sd0, 5'b01000);
    send_str("{\"T\":1,\"L\":{\"T\":2,\"L\":0.050,\"R\":0.000}\n", 0);

    push_err();
    send_str("{\"T\"", 0);
    base = err_pulses;
    repeat (15) @(posedge clk);
    #1;
    check("no_early_timeout", 64'(err_pulses), 64'(base));
    repeat (2) @(posedge clk);
    #1;
    check("timeout_fired", 64'(err_pulses), 64'(base + 1));

    push_err();
    send_str("{\"T\":256,", 0);

    push_ok(8'd255, 16'sd9999, -16'sd9999, 5'b00000);
    send_str("{\"T\":255,\"L\":9.999,\"R\":-9.999}\n", 0);

    push_err();
    send_str("{\"T\":1,\"L\":0.1234,", 0);

    push_ok(8'd7, 16'sd0, 16'sd0, 5'b00001);
    send_str("{\"T\":7,\"L\":-0.000,\"R\":0.0}\n", 0);

    push_ok(8'd3, 16'sd0, 16'sd50, 5'b00100);
    send_str("ab{\"T\":3,\"L\":0.0,\"R\":0.05}\n", 1);

    send_str("{\"T\":1,\"L\":0.", 0);
    rst_n = 1'b0;
    #1;
    check("midframe_reset", 64'({t_value, left_speed, right_speed, motor_cmd, u_if.uart_ready}),
          64'({8'd0, 16'd0, 16'd0, 5'b00001, 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_ok(8'd1, 16'sd100, 16'sd100, 5'b00010);
    send_str("{\"T\":1,\"L\":0.100,\"R\":0.100}\n", 0);

    repeat (30) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
